acc_dvd: RTL and testbench
==========================

# acc_dvd

Byte-serial 16-bit unsigned division accelerator. An input wrapper assembles two 16-bit operands from four bytes. A sequential restoring divider computes the quotient and remainder. An output wrapper then presents the results as four bytes to a downstream reader. It sits between an 8-bit producer bus and an 8-bit consumer bus, with independent resets for the input and output sides.

## Interface
- `NBYTES`, default 4: bytes per operand set and per result set; fixed, not to be overridden.
- `clk` in, 1: single clock; all state changes on the rising edge.
- `rstIw` in, 1: asynchronous active-high reset of the input wrapper and the divider.
- `rstOw` in, 1: asynchronous active-high reset of the output wrapper only.
- `StartData` in, 1: write strobe; `Input_Data` is captured on each rising edge where this is 1 and `ReadyToAccept` is 1.
- `ReceiveData` in, 1: read strobe; pops one result byte on each rising edge where this is 1 and `OutBuffFull` is 1.
- `Input_Data` in, 8: operand byte.
- `OutBuffFull` out, 1: the output wrapper holds a complete 4-byte result.
- `ReadyToAccept` out, 1: the input wrapper can take another byte.
- `Output_Data` out, 8: current result byte at the head of the output buffer.

## Operation
- Byte order in: dividend[15:8], dividend[7:0], divisor[15:8], divisor[7:0].
- Byte order out: quotient[15:8], quotient[7:0], remainder[15:8], remainder[7:0].
- Input wrapper: 2-bit byte counter plus two 16-bit operand registers.
  - `ReadyToAccept` = 1 while fewer than 4 bytes are held and the divider is idle.
  - Strobes while `ReadyToAccept` = 0 are ignored with no side effect.
- Divider FSM has three states: IDLE, CALC and HOLD.
  - IDLE -> CALC the cycle after the 4th byte is captured.
  - CALC performs one restoring step per cycle for 16 cycles.
  - CALC -> HOLD when the last step completes.
  - HOLD -> IDLE on the cycle the result is transferred into an empty output buffer. The input counter clears on the same cycle.
- Divide by zero: quotient = 16'hFFFF, remainder = dividend. No error flag.
- Output wrapper: 4x8 register array plus a 2-bit read pointer.
  - A transfer loads all 4 bytes, resets the pointer to 0 and sets `OutBuffFull` = 1.
  - Each accepted `ReceiveData` advances the pointer.
  - The 4th read clears `OutBuffFull`.
- `Output_Data` = byte at the read pointer while `OutBuffFull` = 1, otherwise 8'h00.
- If `OutBuffFull` = 1 when the divider reaches HOLD, the divider stalls in HOLD until the buffer drains or `rstOw` clears it. The result is never dropped or overwritten.

## Timing
- Reset values: `ReadyToAccept` = 1 after `rstIw`; `OutBuffFull` = 0 and `Output_Data` = 0 after `rstOw`.
- `rstIw` leaves the output wrapper untouched; `rstOw` leaves the input side and the divider untouched.
- Latency from the edge capturing the 4th byte to `OutBuffFull` = 1 is 18 cycles: 1 to start, 16 in CALC, 1 to transfer. This assumes the output buffer is empty.
- `ReadyToAccept` falls on the edge capturing the 4th byte. It rises on the transfer edge.
- A `ReceiveData` on the transfer edge is ignored; the buffer was empty before that edge.
- Strobes are level-sampled: a strobe held for N edges acts N times. Producers pulse for exactly one rising edge.
- `rstIw` mid-CALC aborts the operation: the divider returns to IDLE and its partial result is discarded.
- `rstOw` mid-read discards the remaining bytes.
- `rstOw` while the divider is in CALC or HOLD: the pending result still transfers once ready.

## Structure
- Package `acc_dvd_pkg` holds:
  - `NBYTES` = 4 and `WIDTH` = 16;
  - the divider state enum (IDLE, CALC, HOLD);
  - the byte-order constants.
- Sub-module `dvd_core`: the 16-bit restoring divider with start, done and ack signals. Input and output wrappers stay inline in the top module.

## Test plan
- `rstIw`/`rstOw` pulse, then bytes 0,99,0,10 -> after 18 cycles `OutBuffFull` = 1.
  - Four reads give `Output_Data` 0, 9, 0, 9.
  - `OutBuffFull` = 0 after the 4th read.
- Extra `StartData` after the 4th byte (`ReadyToAccept` = 0) -> ignored; result is still 99/10.
- Dividend 0xFFFF, divisor 0x0000 -> bytes FF, FF, FF, FF.
- Second operand set loaded before the first result is read -> divider stalls in HOLD.
  - Draining the first 4 bytes lets the second result load one cycle later.
- `rstOw` pulse during CALC of 1000/7 -> `OutBuffFull` = 0 during CALC.
  - Result then appears: 0x00, 0x8E, 0x00, 0x06.
- `rstIw` pulse after 2 bytes -> `ReadyToAccept` = 1 and counter = 0.
  - The next 4 bytes, 0,50,0,5, form a fresh operand set and yield 0,10,0,0.

Source files
------------

// File: rtl/acc_dvd_pkg.sv
// rtl/acc_dvd_pkg.sv - shared widths, divider states and byte-order constants for acc_dvd
package acc_dvd_pkg;

    localparam int NBYTES = 4;
    localparam int WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } dvd_state_t;

    // Position of each operand byte in the producer stream
    localparam logic [1:0] IN_DVD_HI = 2'd0;
    localparam logic [1:0] IN_DVD_LO = 2'd1;
    localparam logic [1:0] IN_DSR_HI = 2'd2;
    localparam logic [1:0] IN_DSR_LO = 2'd3;

    // Position of each result byte in the consumer stream
    localparam logic [1:0] OUT_QUO_HI = 2'd0;
    localparam logic [1:0] OUT_QUO_LO = 2'd1;
    localparam logic [1:0] OUT_REM_HI = 2'd2;
    localparam logic [1:0] OUT_REM_LO = 2'd3;

endpackage

// File: rtl/dvd_core.sv
// rtl/dvd_core.sv - 16-bit restoring divider, one quotient bit per cycle, result held until ack
module dvd_core
    import acc_dvd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ack,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    dvd_state_t       state;
    dvd_state_t       state_nxt;
    logic [3:0]       step;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;

    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // A zero divisor always "fits", which naturally yields all-ones quotient and remainder = dividend
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        fits    = (rem_sh >= {1'b0, dsr_q});
        rem_nxt = fits ? WIDTH'(rem_sh - {1'b0, dsr_q}) : rem_sh[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (step == 4'd15) state_nxt = HOLD;
            HOLD:    if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step  <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        step  <= '0;
                        rem_q <= '0;
                        quo_q <= dividend;
                        dsr_q <= divisor;
                    end
                end
                CALC: begin
                    step  <= step + 4'd1;
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == HOLD);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/acc_dvd.sv
// rtl/acc_dvd.sv - byte-serial 16-bit divide accelerator: input assembler, divider core, output buffer
module acc_dvd
    import acc_dvd_pkg::*;
#(
    parameter int NBYTES = acc_dvd_pkg::NBYTES
) (
    input  logic       clk,
    input  logic       rstIw,
    input  logic       rstOw,
    input  logic       StartData,
    input  logic       ReceiveData,
    input  logic [7:0] Input_Data,
    output logic       OutBuffFull,
    output logic       ReadyToAccept,
    output logic [7:0] Output_Data
);

    logic [1:0]       cnt;
    logic             loaded;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;

    logic             busy;
    logic             done;
    logic             start;
    logic             ack;
    logic             capture;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    logic [7:0]       buff [NBYTES];
    logic [1:0]       ptr;
    logic             full;

    assign ReadyToAccept = !loaded && !busy;
    assign capture       = StartData && ReadyToAccept;
    assign start         = loaded && !busy;
    // The handoff waits for an empty buffer so a pending result is never overwritten
    assign ack           = done && !full;

    always_ff @(posedge clk or posedge rstIw) begin
        if (rstIw) begin
            cnt        <= '0;
            loaded     <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
        end else if (ack) begin
            cnt    <= '0;
            loaded <= 1'b0;
        end else if (capture) begin
            case (cnt)
                IN_DVD_HI: dividend_q[15:8] <= Input_Data;
                IN_DVD_LO: dividend_q[7:0]  <= Input_Data;
                IN_DSR_HI: divisor_q[15:8]  <= Input_Data;
                default:   divisor_q[7:0]   <= Input_Data;
            endcase
            cnt <= cnt + 2'd1;
            if (cnt == IN_DSR_LO) begin
                loaded <= 1'b1;
            end
        end
    end

    dvd_core u_core (
        .clk       (clk),
        .rst       (rstIw),
        .start     (start),
        .ack       (ack),
        .dividend  (dividend_q),
        .divisor   (divisor_q),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk or posedge rstOw) begin
        if (rstOw) begin
            full <= 1'b0;
            ptr  <= '0;
            for (int i = 0; i < NBYTES; i++) begin
                buff[i] <= '0;
            end
        end else if (ack) begin
            buff[OUT_QUO_HI] <= quotient[15:8];
            buff[OUT_QUO_LO] <= quotient[7:0];
            buff[OUT_REM_HI] <= remainder[15:8];
            buff[OUT_REM_LO] <= remainder[7:0];
            ptr              <= '0;
            full             <= 1'b1;
        end else if (ReceiveData && full) begin
            ptr <= ptr + 2'd1;
            if (ptr == 2'(NBYTES - 1)) begin
                full <= 1'b0;
            end
        end
    end

    assign OutBuffFull = full;
    assign Output_Data = full ? buff[ptr] : 8'h00;

endmodule

// File: tb/tb_acc_dvd.sv
// tb/tb_acc_dvd.sv - directed and randomized checks of acc_dvd against an arithmetic division model
module tb_acc_dvd;

    logic       clk = 1'b0;
    logic       rstIw = 1'b1;
    logic       rstOw = 1'b1;
    logic       StartData = 1'b0;
    logic       ReceiveData = 1'b0;
    logic [7:0] Input_Data = 8'h00;
    logic       OutBuffFull;
    logic       ReadyToAccept;
    logic [7:0] Output_Data;

    int n_checks = 0;
    int n_fail   = 0;

    acc_dvd dut (
        .clk           (clk),
        .rstIw         (rstIw),
        .rstOw         (rstOw),
        .StartData     (StartData),
        .ReceiveData   (ReceiveData),
        .Input_Data    (Input_Data),
        .OutBuffFull   (OutBuffFull),
        .ReadyToAccept (ReadyToAccept),
        .Output_Data   (Output_Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the four result bytes for a/b, in the order the consumer reads them
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] q;
        logic [15:0] r;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        StartData  = 1'b1;
        Input_Data = b;
        @(negedge clk);
        StartData  = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp);
        check({tag, "_full"}, 16'(OutBuffFull), 16'd1);
        check(tag, 16'(Output_Data), 16'(exp));
        ReceiveData = 1'b1;
        @(negedge clk);
        ReceiveData = 1'b0;
    endtask

    task automatic read_result(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] e;
        e = model(a, b);
        read_byte({tag, "_q_hi"}, e[31:24]);
        read_byte({tag, "_q_lo"}, e[23:16]);
        read_byte({tag, "_r_hi"}, e[15:8]);
        read_byte({tag, "_r_lo"}, e[7:0]);
        check({tag, "_empty"}, 16'(OutBuffFull), 16'd0);
        check({tag, "_empty_data"}, 16'(Output_Data), 16'd0);
    endtask

    task automatic wait_full(input string tag);
        int n;
        n = 0;
        while (!OutBuffFull && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait_full"}, 16'(OutBuffFull), 16'd1);
    endtask

    // Full transaction with exact 18-cycle latency check; extra adds a strobe while not ready
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input bit extra);
        send_op(a, b);
        check({tag, "_rta_low"}, 16'(ReadyToAccept), 16'd0);
        if (extra) begin
            send_byte(8'h55);
            check({tag, "_rta_low2"}, 16'(ReadyToAccept), 16'd0);
            repeat (16) @(negedge clk);
        end else begin
            repeat (17) @(negedge clk);
        end
        check({tag, "_lat17"}, 16'(OutBuffFull), 16'd0);
        @(negedge clk);
        check({tag, "_lat18"}, 16'(OutBuffFull), 16'd1);
        check({tag, "_rta_high"}, 16'(ReadyToAccept), 16'd1);
        read_result(tag, a, b);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] a2;
        logic [15:0] b2;
        logic [31:0] e;

        @(negedge clk);
        check("rst_rta", 16'(ReadyToAccept), 16'd1);
        check("rst_full", 16'(OutBuffFull), 16'd0);
        check("rst_data", 16'(Output_Data), 16'd0);
        @(negedge clk);
        rstIw = 1'b0;
        rstOw = 1'b0;
        @(negedge clk);
        check("post_rst_rta", 16'(ReadyToAccept), 16'd1);

        run_op("basic", 16'd99, 16'd10, 1'b0);
        run_op("extra", 16'd99, 16'd10, 1'b1);
        run_op("div0", 16'hFFFF, 16'h0000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = (i % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 65535));
            run_op($sformatf("rand%0d", i), a, b, 1'b0);
        end

        // Second result stalls in HOLD until the first is drained
        a  = 16'($urandom_range(0, 65535));
        b  = 16'($urandom_range(1, 300));
        a2 = 16'($urandom_range(0, 65535));
        b2 = 16'($urandom_range(1, 65535));
        send_op(a, b);
        wait_full("stall_a");
        send_op(a2, b2);
        repeat (25) @(negedge clk);
        e = model(a, b);
        check("stall_full", 16'(OutBuffFull), 16'd1);
        check("stall_head", 16'(Output_Data), 16'(e[31:24]));
        check("stall_rta", 16'(ReadyToAccept), 16'd0);
        read_byte("stall_a_q_hi", e[31:24]);
        read_byte("stall_a_q_lo", e[23:16]);
        read_byte("stall_a_r_hi", e[15:8]);
        read_byte("stall_a_r_lo", e[7:0]);
        check("stall_drained", 16'(OutBuffFull), 16'd0);
        @(negedge clk);
        check("stall_b_loaded", 16'(OutBuffFull), 16'd1);
        read_result("stall_b", a2, b2);

        // Output reset during CALC: result still arrives afterwards
        send_op(16'd1000, 16'd7);
        repeat (5) @(negedge clk);
        rstOw = 1'b1;
        @(negedge clk);
        rstOw = 1'b0;
        check("rstow_calc_full", 16'(OutBuffFull), 16'd0);
        check("rstow_calc_rta", 16'(ReadyToAccept), 16'd0);
        wait_full("rstow_calc");
        read_byte("rstow_q_hi", 8'h00);
        read_byte("rstow_q_lo", 8'h8E);
        read_byte("rstow_r_hi", 8'h00);
        read_byte("rstow_r_lo", 8'h06);

        // Output reset mid-read discards remaining bytes
        send_op(16'd5000, 16'd3);
        wait_full("rstow_mid");
        e = model(16'd5000, 16'd3);
        read_byte("rstow_mid_q_hi", e[31:24]);
        read_byte("rstow_mid_q_lo", e[23:16]);
        rstOw = 1'b1;
        @(negedge clk);
        rstOw = 1'b0;
        check("rstow_mid_full", 16'(OutBuffFull), 16'd0);
        check("rstow_mid_data", 16'(Output_Data), 16'd0);
        check("rstow_mid_rta", 16'(ReadyToAccept), 16'd1);

        // Input reset after two bytes restarts operand assembly
        send_byte(8'hAB);
        send_byte(8'hCD);
        rstIw = 1'b1;
        @(negedge clk);
        rstIw = 1'b0;
        check("rstiw_part_rta", 16'(ReadyToAccept), 16'd1);
        run_op("rstiw_part", 16'd50, 16'd5, 1'b0);

        // Input reset mid-CALC aborts with no result
        send_op(16'd777, 16'd3);
        repeat (6) @(negedge clk);
        rstIw = 1'b1;
        @(negedge clk);
        rstIw = 1'b0;
        check("abort_rta", 16'(ReadyToAccept), 16'd1);
        repeat (25) @(negedge clk);
        check("abort_no_result", 16'(OutBuffFull), 16'd0);
        run_op("after_abort", 16'd4321, 16'd17, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
